// File: rtl/tone_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tone_sequencer: song ROM walker driving a square-wave buzzer with duty    |
// | (volume) control, pause, loop and done pulse.       Revision: 1.0         |
// +----------------------------------------------------------------------------+
module tone_sequencer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 8,
  parameter int ADDR_W  = 6,
  parameter int DUR_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [1:0]        vol,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DUR_W+4:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [4:0]        note_cur,
  output logic              pwm_out
);

  localparam int c_TICK   = CLK_HZ / TICK_HZ;
  localparam int c_TICK_W = (c_TICK > 1) ? $clog2(c_TICK) : 1;
  localparam int c_PMAX   = CLK_HZ / 262;
  localparam int c_PH_W   = $clog2(c_PMAX + 1);
  localparam int c_REM_W  = DUR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_wrap;
  logic [c_TICK_W-1:0]  r_tick;
  logic [c_REM_W-1:0]   r_rem;
  logic [c_PH_W-1:0]    r_phase, r_period, w_high;
  logic [4:0]           r_note;
  logic                 r_audible;

  logic [4:0]           w_note_in;
  logic [DUR_W-1:0]     w_dur_in;
  logic                 w_end, w_tick_end, w_last;

  function automatic int period_of(input logic [4:0] n);
    case (n)
      5'd1:    period_of = CLK_HZ / 262;
      5'd2:    period_of = CLK_HZ / 294;
      5'd3:    period_of = CLK_HZ / 330;
      5'd4:    period_of = CLK_HZ / 349;
      5'd5:    period_of = CLK_HZ / 392;
      5'd6:    period_of = CLK_HZ / 440;
      5'd7:    period_of = CLK_HZ / 494;
      5'd8:    period_of = CLK_HZ / 523;
      5'd9:    period_of = CLK_HZ / 587;
      5'd10:   period_of = CLK_HZ / 659;
      5'd11:   period_of = CLK_HZ / 698;
      5'd12:   period_of = CLK_HZ / 784;
      5'd13:   period_of = CLK_HZ / 880;
      5'd14:   period_of = CLK_HZ / 988;
      5'd15:   period_of = CLK_HZ / 1046;
      5'd16:   period_of = CLK_HZ / 1175;
      5'd17:   period_of = CLK_HZ / 1319;
      5'd18:   period_of = CLK_HZ / 1397;
      5'd19:   period_of = CLK_HZ / 1568;
      5'd20:   period_of = CLK_HZ / 1760;
      5'd21:   period_of = CLK_HZ / 1976;
      default: period_of = 0;
    endcase
  endfunction

  assign w_note_in  = rd_data[4:0];
  assign w_dur_in   = rd_data[DUR_W+4:5];
  assign w_end      = (w_note_in == 5'd31) || r_wrap;
  assign w_tick_end = (r_tick == c_TICK_W'(c_TICK - 1));
  assign w_last     = w_tick_end && (r_rem == c_REM_W'(1));
  assign w_high     = r_period >> ({1'b0, vol} + 3'd1);
  assign rd_addr    = r_addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    note_cur    = (r_state == S_PLAY) ? r_note : 5'd0;
    pwm_out     = (r_state == S_PLAY) && r_audible && !pause && (r_phase < w_high);
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  begin
        if (w_end) w_state_nxt = loop ? S_FETCH : S_DONE;
        else       w_state_nxt = S_PLAY;
      end
      S_PLAY:  if (!pause && w_last) w_state_nxt = S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (stop) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr    <= '0;
      r_wrap    <= 1'b0;
      r_tick    <= '0;
      r_rem     <= '0;
      r_phase   <= '0;
      r_period  <= '0;
      r_note    <= '0;
      r_audible <= 1'b0;
    end else if (stop) begin
      r_addr    <= '0;
      r_wrap    <= 1'b0;
      r_tick    <= '0;
      r_rem     <= '0;
      r_phase   <= '0;
      r_audible <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_addr <= '0;
          r_wrap <= 1'b0;
        end
        S_LOAD: begin
          r_note    <= w_note_in;
          r_audible <= (w_note_in >= 5'd1) && (w_note_in <= 5'd21);
          r_period  <= c_PH_W'(period_of(w_note_in));
          r_tick    <= '0;
          r_phase   <= '0;
          r_rem     <= (w_dur_in == '0) ? c_REM_W'(1 << DUR_W) : {1'b0, w_dur_in};
          if (w_end) begin
            r_addr <= '0;
            r_wrap <= 1'b0;
          end
        end
        S_PLAY: if (!pause) begin
          if (w_tick_end) begin
            r_tick <= '0;
            r_rem  <= r_rem - c_REM_W'(1);
          end else begin
            r_tick <= r_tick + c_TICK_W'(1);
          end
          if (r_audible)
            r_phase <= (r_phase == r_period - c_PH_W'(1)) ? '0 : r_phase + c_PH_W'(1);
          // Running off the top of the ROM is flagged so LOAD treats it as end of song
          if (w_last) begin
            if (r_addr == '1) begin
              r_addr <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tone_sequencer: directed self-checking bench for tone_sequencer.       |
// |                                                      Revision: 1.0       |
// +----------------------------------------------------------------------------+
module tb_tone_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
  logic [1:0] vol = 2'd0;
  logic [5:0] rd_addr;
  logic [8:0] rd_data;
  logic       busy, done, pwm_out;
  logic [4:0] note_cur;
  logic [8:0] rom [64];

  int tests = 0;
  int failed = 0;
  int n, fall, rise, cnt;

  tone_sequencer #(.CLK_HZ(1_000_000), .TICK_HZ(100), .ADDR_W(6), .DUR_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .vol(vol), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .note_cur(note_cur), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rom[rd_addr];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // leaves the bench sampling the first PLAY cycle
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  task automatic measure(input logic [4:0] note, output int len, output int f, output int r);
    len = 0; f = -1; r = -1;
    while (note_cur == note && len < 40000) begin
      if (!pwm_out && f < 0) f = len;
      if (pwm_out && f >= 0 && r < 0) r = len;
      len++;
      step();
    end
  endtask

  // entered on the FETCH sample following the last note
  task automatic finish_song(input string tag);
    check({tag, "_gap_pwm"}, pwm_out, 0);
    step();
    check({tag, "_load_pwm"}, pwm_out, 0);
    step();
    check({tag, "_done"}, done, 1);
    step();
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 9'd0;
    #2 rstn = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_note", note_cur, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_addr", rd_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    step();

    // A4 for 2 ticks then end marker
    rom[0] = {4'd2, 5'd6};
    rom[1] = {4'd0, 5'd31};
    start = 1'b1;
    step();
    start = 1'b0;
    check("fetch_busy", busy, 1);
    check("fetch_pwm", pwm_out, 0);
    step();
    check("load_pwm", pwm_out, 0);
    step();
    check("play_pwm", pwm_out, 1);
    check("play_note", note_cur, 6);
    measure(5'd6, n, fall, rise);
    check("a4_high", fall, 1136);
    check("a4_period", rise, 2272);
    check("a4_len", n, 20000);
    check("a4_next_addr", rd_addr, 1);
    finish_song("a4");

    // C5 at vol=2
    rom[0] = {4'd1, 5'd8};
    vol = 2'd2;
    do_start();
    measure(5'd8, n, fall, rise);
    check("c5v2_high", fall, 239);
    check("c5v2_period", rise, 1912);
    check("c5v2_len", n, 10000);
    finish_song("c5v2");
    vol = 2'd0;

    // rest, E5, end with loop enabled
    rom[0] = {4'd1, 5'd0};
    rom[1] = {4'd1, 5'd10};
    rom[2] = {4'd0, 5'd31};
    loop = 1'b1;
    do_start();
    check("rest_pwm", pwm_out, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    cnt = 0;
    while (rd_addr == 6'd0 && n < 20000) begin
      if (pwm_out) cnt++;
      step();
      n++;
    end
    check("rest_len", n, 10000);
    check("rest_silent", cnt, 0);
    check("gap1_pwm", pwm_out, 0);
    step();
    check("gap2_pwm", pwm_out, 0);
    step();
    check("e5_note", note_cur, 10);
    measure(5'd10, n, fall, rise);
    check("e5_high", fall, 758);
    check("e5_period", rise, 1517);
    check("e5_len", n, 10000);
    step();
    step();
    check("loop_addr", rd_addr, 0);
    check("loop_busy", busy, 1);
    check("loop_nodone", done, 0);
    step();
    step();
    step();
    check("loop_rest_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
    loop = 1'b0;

    // pause 5000 cycles mid-note
    rom[0] = {4'd1, 5'd6};
    rom[1] = {4'd0, 5'd31};
    do_start();
    repeat (500) step();
    pause = 1'b1;
    #1;
    check("pause_pwm", pwm_out, 0);
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (pwm_out) cnt++;
    end
    check("pause_silent", cnt, 0);
    check("pause_hold_note", note_cur, 6);
    pause = 1'b0;
    #1;
    measure(5'd6, n, fall, rise);
    check("resume_high", fall, 636);
    check("resume_len", n, 9500);
    finish_song("pause");

    // stop mid-note, then start+stop in IDLE
    do_start();
    repeat (300) step();
    check("pre_stop_pwm", pwm_out, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_pwm", pwm_out, 0);
    check("stop_note", note_cur, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) cnt++;
      step();
    end
    check("stop_nodone", cnt, 0);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("startstop_busy", busy, 0);

    // async reset mid-note
    do_start();
    repeat (100) step();
    rstn = 1'b0;
    #1;
    check("arst_pwm", pwm_out, 0);
    check("arst_busy", busy, 0);
    check("arst_note", note_cur, 0);
    @(negedge clk) rstn = 1'b1;
    step();
    do_start();
    check("restart_pwm", pwm_out, 1);
    check("restart_note", note_cur, 6);
    stop = 1'b1;
    step();
    stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
